// File: rtl/stack_sort_pkg.sv
// rtl/stack_sort_pkg.sv - shared types and constants for the 3D-stack ID-sort protocol
//
// Purpose: frame layout, frame type codes, signature and FSM state encoding
//          shared by the base-layer master and the per-layer node.
// Contents:
//   SIG            frame signature carried in bits [15:0]
//   frame_type_e   [31:30] frame type codes
//   frame_t        packed view of a 32-bit frame
//   sort_state_e   master FSM states
//   make_frame()   builds a frame with a valid signature

package stack_sort_pkg;

  localparam logic [15:0] SIG = 16'hBEAF;

  typedef enum logic [1:0] {
    TYPE_NONE  = 2'b00,
    TYPE_ACK   = 2'b01,
    TYPE_TOKEN = 2'b10,
    TYPE_TERM  = 2'b11
  } frame_type_e;

  typedef struct packed {
    frame_type_e ftype;    // [31:30]
    logic [3:0]  power;    // [29:26]
    logic [4:0]  src_id;   // [25:21] sender chip_id
    logic [4:0]  next_id;  // [20:16]
    logic [15:0] sig;      // [15:0]
  } frame_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_DONE,
    ST_ERR
  } sort_state_e;

  function automatic logic [31:0] make_frame(input frame_type_e ftype,
                                             input logic [3:0]  power,
                                             input logic [4:0]  src_id,
                                             input logic [4:0]  next_id);
    frame_t f;
    f.ftype   = ftype;
    f.power   = power;
    f.src_id  = src_id;
    f.next_id = next_id;
    f.sig     = SIG;
    return f;
  endfunction

endpackage

// File: rtl/stack_sort_if.sv
// rtl/stack_sort_if.sv - vertical TSV link between stacked dies
//
// Purpose: bundles the upward frame channel (valid/ready) and the downward
//          frame channel (valid only, no backpressure).
// Signals:
//   tx_data  [31:0]  frame to the upper layer
//   tx_valid         tx_data valid, held until tx_ready
//   tx_ready         link accepts the frame this cycle
//   rx_data  [31:0]  frame from the upper layers
//   rx_valid         rx_data valid for one cycle
// Modports: master (base die), slave (link / upper layers)

interface stack_sort_if;

  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid
  );

endinterface

// File: rtl/stack_frame_check.sv
// rtl/stack_frame_check.sv - combinational decode of a received frame
//
// Purpose: splits rx_data into its fields and checks signature and sender id.
// Ports:
//   rx_data [31:0]  in   received frame
//   exp_id  [5:0]   in   chip_id expected next (6 bits so MAX_LAYERS+1 fits)
//   sig_ok          out  signature equals SIG
//   ftype   [1:0]   out  frame type
//   power   [3:0]   out  power step field
//   id      [4:0]   out  sender chip_id
//   id_ok           out  sender chip_id equals exp_id

module stack_frame_check
  import stack_sort_pkg::*;
(
  input  logic [31:0] rx_data,
  input  logic [5:0]  exp_id,
  output logic        sig_ok,
  output frame_type_e ftype,
  output logic [3:0]  power,
  output logic [4:0]  id,
  output logic        id_ok
);

  frame_t f;
  logic   unused_next_id;

  assign f      = rx_data;
  assign sig_ok = (f.sig == SIG);
  assign ftype  = f.ftype;
  assign power  = f.power;
  assign id     = f.src_id;
  assign id_ok  = ({1'b0, f.src_id} == exp_id);

  // The master identifies layers by sender id only.
  assign unused_next_id = ^f.next_id;

endmodule

// File: rtl/stack_sort_master.sv
// rtl/stack_sort_master.sv - base-layer initiator of the 3D-stack ID-sort protocol
//
// Purpose: on start launches the token up the stack, collects one ack per
//          layer, records each layer's power step, and ends on the terminal
//          ack, a timeout after all retries, or a protocol error.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      1-cycle pulse, begins (or restarts) a sort
//   link (stack_sort_if.master) TSV frame link
//   busy / done / error        registered, mutually exclusive status
//   layer_count                layers acknowledged so far
//   rd_idx / rd_power          table read port, 1-cycle latency
//   bad_frames                 frames dropped for bad signature, saturating

module stack_sort_master
  import stack_sort_pkg::*;
#(
  parameter int          MAX_LAYERS = 8,
  parameter int          TIMEOUT    = 1024,
  parameter int          MAX_RETRY  = 2,
  parameter logic [3:0]  POWER_INIT = 4'b0001,
  localparam int         CNT_W      = $clog2(MAX_LAYERS + 1),
  localparam int         IDX_W      = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  stack_sort_if.master      link,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  layer_count,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [3:0]        rd_power,
  output logic [7:0]        bad_frames
);

  localparam int TIMER_W = $clog2(TIMEOUT + 1);
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [31:0] TOKEN = make_frame(TYPE_TOKEN, POWER_INIT, 5'd0, 5'd1);

  sort_state_e        state, state_nx;
  logic [TIMER_W-1:0] timer;
  logic [RETRY_W-1:0] retry;
  logic [3:0]         tbl [MAX_LAYERS];
  logic [31:0]        tx_data_q;
  logic               tx_valid_q;

  // FSM action strobes
  logic do_clear;   // start actions: wipe table, count, retry, timer
  logic do_retry;   // timeout with retries left: wipe table and count, relaunch
  logic do_store;   // accepted ack/term: write table, bump count
  logic bad_inc;
  logic timer_clr;
  logic timer_inc;

  // Decoded receive frame
  logic        sig_ok, id_ok, full;
  frame_type_e ftype;
  logic [3:0]  power;
  logic [4:0]  id;
  logic [5:0]  exp_id;

  assign exp_id = 6'(layer_count) + 6'd1;
  assign full   = (layer_count == CNT_W'(MAX_LAYERS));

  stack_frame_check u_check (
    .rx_data (link.rx_data),
    .exp_id  (exp_id),
    .sig_ok  (sig_ok),
    .ftype   (ftype),
    .power   (power),
    .id      (id),
    .id_ok   (id_ok)
  );

  assign link.tx_data  = tx_data_q;
  assign link.tx_valid = tx_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    do_clear  = 1'b0;
    do_retry  = 1'b0;
    do_store  = 1'b0;
    bad_inc   = 1'b0;
    timer_clr = 1'b0;
    timer_inc = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          do_clear = 1'b1;
          state_nx = ST_SEND;
        end
      end
      ST_SEND: begin
        // tx_valid is always high in SEND, so ready alone completes the handshake.
        if (link.tx_ready) begin
          timer_clr = 1'b1;
          state_nx  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A frame in the timeout cycle takes priority over the timeout.
        if (link.rx_valid) begin
          if (!sig_ok) begin
            bad_inc   = 1'b1;
            timer_inc = 1'b1;
          end else if ((ftype == TYPE_ACK || ftype == TYPE_TERM) &&
                       id_ok && power != 4'd0 && !full) begin
            do_store  = 1'b1;
            timer_clr = 1'b1;
            if (ftype == TYPE_TERM) state_nx = ST_DONE;
          end else begin
            state_nx = ST_ERR;
          end
        end else if (timer >= TIMER_W'(TIMEOUT - 1)) begin
          // >= covers a bad frame that pushed the timer past the limit.
          if (retry < RETRY_W'(MAX_RETRY)) begin
            do_retry = 1'b1;
            state_nx = ST_SEND;
          end else begin
            state_nx = ST_ERR;
          end
        end else begin
          timer_inc = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      timer       <= '0;
      retry       <= '0;
      layer_count <= '0;
      bad_frames  <= '0;
    end else begin
      busy       <= (state_nx == ST_SEND) || (state_nx == ST_WAIT);
      done       <= (state_nx == ST_DONE);
      error      <= (state_nx == ST_ERR);
      tx_valid_q <= (state_nx == ST_SEND);
      tx_data_q  <= (state_nx == ST_SEND) ? TOKEN : '0;

      if (do_clear || do_retry || timer_clr) timer <= '0;
      else if (timer_inc)                    timer <= timer + 1'b1;

      if (do_clear)      retry <= '0;
      else if (do_retry) retry <= retry + 1'b1;

      if (do_clear || do_retry) layer_count <= '0;
      else if (do_store)        layer_count <= layer_count + 1'b1;

      if (bad_inc && bad_frames != 8'hFF) bad_frames <= bad_frames + 8'd1;
    end
  end

  // Ack for chip id N lands in entry N-1, which is the current layer_count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LAYERS; i++) tbl[i] <= 4'd0;
    end else begin
      for (int i = 0; i < MAX_LAYERS; i++) begin
        if (do_clear || do_retry)
          tbl[i] <= 4'd0;
        else if (do_store && int'(layer_count) == i)
          tbl[i] <= power;
      end
    end
  end

  // Indices beyond the table read as 0.
  logic [3:0] rd_val;
  always_comb begin
    rd_val = 4'd0;
    for (int i = 0; i < MAX_LAYERS; i++)
      if (int'(rd_idx) == i) rd_val = tbl[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_power <= 4'd0;
    else        rd_power <= rd_val;
  end

endmodule

// File: tb/tb_stack_sort_master.sv
// tb/tb_stack_sort_master.sv - directed self-checking bench for stack_sort_master

module tb_stack_sort_master;
  import stack_sort_pkg::*;

  localparam int ML = 8;
  localparam int TO = 16;
  localparam int MR = 2;
  localparam logic [31:0] TOKEN_EXP = 32'h8401_BEAF;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] rd_idx;
  logic       busy, done, error;
  logic [3:0] layer_count;
  logic [3:0] rd_power;
  logic [7:0] bad_frames;
  int         vectors = 0;
  int         miscompares = 0;
  int         n;

  stack_sort_if link();

  stack_sort_master #(
    .MAX_LAYERS (ML),
    .TIMEOUT    (TO),
    .MAX_RETRY  (MR),
    .POWER_INIT (4'b0001)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .link        (link),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .layer_count (layer_count),
    .rd_idx      (rd_idx),
    .rd_power    (rd_power),
    .bad_frames  (bad_frames)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] frame(input logic [1:0] t, input logic [3:0] p,
                                        input logic [4:0] id, input logic [15:0] sig);
    return {t, p, id, id + 5'd1, sig};
  endfunction

  task automatic rx(input logic [31:0] d);
    link.rx_data  = d;
    link.rx_valid = 1'b1;
    tick();
    link.rx_valid = 1'b0;
    link.rx_data  = '0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic handshake(input string tag);
    int k = 0;
    while (!link.tx_valid && k < 4 * TO) begin
      tick();
      k++;
    end
    check_eq({tag, "_txv"}, 32'(link.tx_valid), 32'd1);
    link.tx_ready = 1'b1;
    tick();
    check_eq({tag, "_hs"}, 32'(link.tx_valid), 32'd0);
  endtask

  task automatic silence(output int k);
    k = 0;
    while (!link.tx_valid && !error && k < 4 * TO) begin
      tick();
      k++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    rd_idx        = '0;
    link.tx_ready = 1'b1;
    link.rx_valid = 1'b0;
    link.rx_data  = '0;
    repeat (2) tick();
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_error", 32'(error), 0);
    check_eq("rst_txv", 32'(link.tx_valid), 0);
    check_eq("rst_txd", link.tx_data, 0);
    check_eq("rst_cnt", 32'(layer_count), 0);
    check_eq("rst_bad", 32'(bad_frames), 0);
    check_eq("rst_rdp", 32'(rd_power), 0);
    rst_n = 1'b1;
    tick();

    // 1: basic three-layer sort
    do_start();
    check_eq("t1_busy", 32'(busy), 1);
    check_eq("t1_token", link.tx_data, TOKEN_EXP);
    handshake("t1");
    rx(frame(2'b01, 4'd3, 5'd1, SIG));
    rx(frame(2'b01, 4'd5, 5'd2, SIG));
    check_eq("t1_cnt2", 32'(layer_count), 2);
    check_eq("t1_busy2", 32'(busy), 1);
    rx(frame(2'b11, 4'd2, 5'd3, SIG));
    check_eq("t1_done", 32'(done), 1);
    check_eq("t1_nbusy", 32'(busy), 0);
    check_eq("t1_cnt", 32'(layer_count), 3);
    rd_idx = 3'd0; tick(); check_eq("t1_rd0", 32'(rd_power), 3);
    rd_idx = 3'd1; tick(); check_eq("t1_rd1", 32'(rd_power), 5);
    rd_idx = 3'd2; tick(); check_eq("t1_rd2", 32'(rd_power), 2);
    rd_idx = 3'd3; tick(); check_eq("t1_rd3", 32'(rd_power), 0);

    // 2: backpressure in SEND
    link.tx_ready = 1'b0;
    do_start();
    check_eq("t2_done_clr", 32'(done), 0);
    check_eq("t2_cnt_clr", 32'(layer_count), 0);
    for (int i = 0; i < 5; i++) begin
      check_eq("t2_txv", 32'(link.tx_valid), 1);
      check_eq("t2_txd", link.tx_data, TOKEN_EXP);
      check_eq("t2_timer", 32'(dut.timer), 0);
      tick();
    end
    handshake("t2");
    check_eq("t2_busy", 32'(busy), 1);

    // 3: silence -> two retries, then error
    silence(n);
    check_eq("t3_gap1", n, TO);
    check_eq("t3_retry1", 32'(dut.retry), 1);
    check_eq("t3_busy1", 32'(busy), 1);
    handshake("t3a");
    silence(n);
    check_eq("t3_gap2", n, TO);
    check_eq("t3_retry2", 32'(dut.retry), 2);
    handshake("t3b");
    silence(n);
    check_eq("t3_gap3", n, TO);
    check_eq("t3_error", 32'(error), 1);
    check_eq("t3_nbusy", 32'(busy), 0);
    check_eq("t3_txv", 32'(link.tx_valid), 0);

    // 4: bad signature mid-sort is dropped
    do_start();
    check_eq("t4_err_clr", 32'(error), 0);
    handshake("t4");
    rx(frame(2'b01, 4'd4, 5'd1, SIG));
    rx(frame(2'b01, 4'd6, 5'd2, 16'hDEAD));
    check_eq("t4_bad", 32'(bad_frames), 1);
    check_eq("t4_cnt1", 32'(layer_count), 1);
    rx(frame(2'b01, 4'd6, 5'd2, SIG));
    rx(frame(2'b11, 4'd8, 5'd3, SIG));
    check_eq("t4_done", 32'(done), 1);
    check_eq("t4_cnt", 32'(layer_count), 3);
    rd_idx = 3'd1; tick(); check_eq("t4_rd1", 32'(rd_power), 6);

    // 5: wrong id, zero power, rx outside WAIT
    do_start();
    handshake("t5a");
    rx(frame(2'b01, 4'd3, 5'd2, SIG));
    check_eq("t5_id_err", 32'(error), 1);
    check_eq("t5_id_cnt", 32'(layer_count), 0);
    rx(frame(2'b01, 4'd3, 5'd1, 16'hDEAD));
    check_eq("t5_idle_bad", 32'(bad_frames), 1);
    do_start();
    check_eq("t5_restart_err", 32'(error), 0);
    check_eq("t5_restart_busy", 32'(busy), 1);
    handshake("t5b");
    rx(frame(2'b01, 4'd0, 5'd1, SIG));
    check_eq("t5_pwr_err", 32'(error), 1);
    do_start();
    handshake("t5c");
    rx(frame(2'b10, 4'd3, 5'd1, SIG));
    check_eq("t5_type_err", 32'(error), 1);

    // 6: terminal ack in the timeout cycle, then reset in WAIT
    do_start();
    handshake("t6a");
    rx(frame(2'b01, 4'd7, 5'd1, SIG));
    repeat (TO - 1) tick();
    check_eq("t6_timer", 32'(dut.timer), TO - 1);
    rx(frame(2'b11, 4'd6, 5'd2, SIG));
    check_eq("t6_done", 32'(done), 1);
    check_eq("t6_cnt", 32'(layer_count), 2);
    check_eq("t6_retry", 32'(dut.retry), 0);
    check_eq("t6_txv", 32'(link.tx_valid), 0);
    rd_idx = 3'd1; tick(); check_eq("t6_rd1", 32'(rd_power), 6);

    do_start();
    handshake("t6b");
    rx(frame(2'b01, 4'd9, 5'd1, SIG));
    rd_idx = 3'd0; tick(); check_eq("t6_rd_pre", 32'(rd_power), 9);
    rst_n = 1'b0;
    #1;
    check_eq("t6r_busy", 32'(busy), 0);
    check_eq("t6r_done", 32'(done), 0);
    check_eq("t6r_error", 32'(error), 0);
    check_eq("t6r_cnt", 32'(layer_count), 0);
    check_eq("t6r_bad", 32'(bad_frames), 0);
    check_eq("t6r_rdp", 32'(rd_power), 0);
    check_eq("t6r_txv", 32'(link.tx_valid), 0);
    check_eq("t6r_txd", link.tx_data, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("t6r_tbl0", 32'(rd_power), 0);
    check_eq("t6r_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
